// File: rtl/hy_matched_filter_if.sv
// hy_matched_filter_if: stream and status bundle between the H/Y buffers, the matched filter and the metric units.
interface hy_matched_filter_if #(
  parameter int N    = 16,
  parameter int NT   = 4,
  parameter int NSYM = 2
);
  localparam int TW = NT > 1 ? $clog2(NT) : 1;
  localparam int KW = NSYM > 1 ? $clog2(NSYM) : 1;
  logic                start;
  logic                h_valid, h_ready;
  logic signed [N-1:0] h_r, h_i;
  logic                y_valid, y_ready;
  logic signed [N-1:0] y_r, y_i;
  logic                z_valid, z_ready;
  logic signed [N-1:0] z_r, z_i;
  logic [TW-1:0]       z_tx;
  logic [KW-1:0]       z_sym;
  logic                busy, done, sat_flag;
  modport master (
    output start, h_valid, h_r, h_i, y_valid, y_r, y_i, z_ready,
    input  h_ready, y_ready, z_valid, z_r, z_i, z_tx, z_sym, busy, done, sat_flag
  );
  modport slave (
    input  start, h_valid, h_r, h_i, y_valid, y_r, y_i, z_ready,
    output h_ready, y_ready, z_valid, z_r, z_i, z_tx, z_sym, busy, done, sat_flag
  );
endinterface

// File: rtl/hy_matched_filter.sv
// hy_matched_filter: streams H then Y and emits Z = H^H * Y per symbol, rounded and saturated.
module hy_matched_filter #(
  parameter int N         = 16,
  parameter int Q         = 8,
  parameter int ACC_WIDTH = 40,
  parameter int NR        = 4,
  parameter int NT        = 4,
  parameter int NSYM      = 2
) (
  input logic clk,
  input logic rst_n,
  hy_matched_filter_if.slave bus
);
  localparam int RW = NR > 1 ? $clog2(NR) : 1;
  localparam int TW = NT > 1 ? $clog2(NT) : 1;
  localparam int KW = NSYM > 1 ? $clog2(NSYM) : 1;
  localparam logic signed [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] MAXA = ACC_WIDTH'(MAXN);
  localparam logic signed [ACC_WIDTH-1:0] MINA = ACC_WIDTH'(MINN);
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (Q - 1);
  typedef enum logic [2:0] {IDLE, LOAD_H, ACC_Y, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic signed [N-1:0] hr [NR][NT];
  logic signed [N-1:0] hi [NR][NT];
  logic signed [ACC_WIDTH-1:0] acc_r [NT];
  logic signed [ACC_WIDTH-1:0] acc_i [NT];
  logic signed [ACC_WIDTH-1:0] sr, si;
  logic [RW-1:0] hrow, r;
  logic [TW-1:0] hcol, t;
  logic [KW-1:0] k;
  logic sat, clip_r, clip_i;
  logic h_hs, y_hs, z_hs, h_last, y_last, z_last, k_last;
  function automatic logic signed [ACC_WIDTH-1:0] sx(input logic signed [N-1:0] v);
    return ACC_WIDTH'(v);
  endfunction
  assign h_hs   = bus.h_valid && state == LOAD_H;
  assign y_hs   = bus.y_valid && state == ACC_Y;
  assign z_hs   = bus.z_ready && state == DRAIN;
  assign h_last = hrow == RW'(NR - 1) && hcol == TW'(NT - 1);
  assign y_last = r == RW'(NR - 1);
  assign z_last = t == TW'(NT - 1);
  assign k_last = k == KW'(NSYM - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = bus.start ? LOAD_H :
          (h_hs && h_last) ? ACC_Y :
          (y_hs && y_last) ? DRAIN :
          (z_hs && z_last) ? (k_last ? DONE : ACC_Y) :
          state == DONE ? IDLE : state;
  end
  // round half up, then clip to the N-bit signed range
  always_comb begin
    sr = (acc_r[t] + HALF) >>> Q;
    si = (acc_i[t] + HALF) >>> Q;
    clip_r = sr > MAXA || sr < MINA;
    clip_i = si > MAXA || si < MINA;
  end
  assign bus.z_r      = clip_r ? (sr[ACC_WIDTH-1] ? MINN : MAXN) : sr[N-1:0];
  assign bus.z_i      = clip_i ? (si[ACC_WIDTH-1] ? MINN : MAXN) : si[N-1:0];
  assign bus.z_tx     = t;
  assign bus.z_sym    = k;
  assign bus.z_valid  = state == DRAIN;
  assign bus.h_ready  = state == LOAD_H;
  assign bus.y_ready  = state == ACC_Y;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  assign bus.sat_flag = sat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {hrow, hcol, r, t, k, sat} <= '0;
      for (int a = 0; a < NR; a++)
        for (int b = 0; b < NT; b++) begin
          hr[a][b] <= '0;
          hi[a][b] <= '0;
        end
      for (int j = 0; j < NT; j++) begin
        acc_r[j] <= '0;
        acc_i[j] <= '0;
      end
    end else if (bus.start) begin
      {hrow, hcol, r, t, k, sat} <= '0;
      for (int j = 0; j < NT; j++) begin
        acc_r[j] <= '0;
        acc_i[j] <= '0;
      end
    end else begin
      if (h_hs) begin
        hr[hrow][hcol] <= bus.h_r;
        hi[hrow][hcol] <= bus.h_i;
        hcol <= hcol == TW'(NT - 1) ? '0 : hcol + 1'b1;
        if (hcol == TW'(NT - 1)) hrow <= h_last ? '0 : hrow + 1'b1;
      end
      // one complex MAC per transmit stream against conj(H[r][t])
      if (y_hs) begin
        for (int j = 0; j < NT; j++) begin
          acc_r[j] <= acc_r[j] + sx(hr[r][j]) * sx(bus.y_r) + sx(hi[r][j]) * sx(bus.y_i);
          acc_i[j] <= acc_i[j] + sx(hr[r][j]) * sx(bus.y_i) - sx(hi[r][j]) * sx(bus.y_r);
        end
        r <= y_last ? '0 : r + 1'b1;
      end
      if (z_hs) begin
        sat <= sat | clip_r | clip_i;
        t <= z_last ? '0 : t + 1'b1;
        if (z_last) begin
          k <= k_last ? '0 : k + 1'b1;
          for (int j = 0; j < NT; j++) begin
            acc_r[j] <= '0;
            acc_i[j] <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hy_matched_filter.sv
// tb_hy_matched_filter: directed blocks with hand-computed Z queued for a negedge monitor.
module tb_hy_matched_filter;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  hy_matched_filter_if #(.N(16), .NT(4), .NSYM(2)) bus ();
  hy_matched_filter #(.N(16), .Q(8), .ACC_WIDTH(40), .NR(4), .NT(4), .NSYM(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {logic [15:0] r; logic [15:0] i; int tx; int sym;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] hr_m [4][4];
  logic [15:0] hi_m [4][4];
  logic [15:0] yr_m [2][4];
  logic [15:0] yi_m [2][4];
  logic [15:0] zr_e [2][4];
  logic [15:0] zi_e [2][4];
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.z_valid && bus.z_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_z got t=%0d k=%0d r=%h i=%h exp no output", bus.z_tx, bus.z_sym, bus.z_r, bus.z_i);
      end else begin
        e = q.pop_front();
        if (bus.z_r !== e.r || bus.z_i !== e.i || int'(bus.z_tx) != e.tx || int'(bus.z_sym) != e.sym) begin
          fails++;
          $display("FAIL z[%0d][%0d] got r=%h i=%h t=%0d k=%0d exp r=%h i=%h t=%0d k=%0d",
                   e.tx, e.sym, bus.z_r, bus.z_i, bus.z_tx, bus.z_sym, e.r, e.i, e.tx, e.sym);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s got %h exp %h", n, a, x);
    end
  endtask
  task automatic hs(input bit is_y);
    int n = 0;
    forever begin
      @(negedge clk);
      if (is_y ? bus.y_ready : bus.h_ready) break;
      if (++n > 200) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout got ready=0 exp ready=1", is_y ? "y" : "h");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.h_valid = 0;
    bus.y_valid = 0;
  endtask
  task automatic start_pulse();
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
  endtask
  task automatic load_h();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        bus.h_valid = 1;
        bus.h_r = hr_m[a][b];
        bus.h_i = hi_m[a][b];
        hs(0);
      end
  endtask
  task automatic send_y(input int k, input int beats, input bit push);
    if (push)
      for (int b = 0; b < 4; b++) q.push_back('{zr_e[k][b], zi_e[k][b], b, k});
    for (int a = 0; a < beats; a++) begin
      bus.y_valid = 1;
      bus.y_r = yr_m[k][a];
      bus.y_i = yi_m[k][a];
      hs(1);
    end
  endtask
  task automatic wait_done(input string n);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk({n, "_done"}, 32'(seen), 1);
    @(negedge clk);
    chk({n, "_idle_busy"}, 32'(bus.busy), 0);
    chk({n, "_queue_left"}, q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_zvalid(input string n);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.z_valid;
    end
    chk(n, 32'(seen), 1);
  endtask
  task automatic set_identity();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        hr_m[a][b] = (a == b) ? 16'h0100 : 16'h0000;
        hi_m[a][b] = 16'h0000;
      end
    for (int a = 0; a < 4; a++) begin
      yr_m[0][a] = 16'(256 * (a + 1));
      yi_m[0][a] = 16'h0000;
      zr_e[0][a] = 16'(256 * (a + 1));
      zi_e[0][a] = 16'h0000;
      yr_m[1][a] = 16'h0000;
      zr_e[1][a] = 16'h0000;
    end
    yi_m[1][0] = 16'h0100; yi_m[1][1] = 16'h0000; yi_m[1][2] = 16'h0000; yi_m[1][3] = 16'hFF00;
    for (int a = 0; a < 4; a++) zi_e[1][a] = yi_m[1][a];
  endtask
  task automatic set_conj();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        hr_m[a][b] = 16'h0000;
        hi_m[a][b] = 16'h0000;
      end
    hi_m[0][0] = 16'h0100;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4; a++) begin
        yr_m[k][a] = (a == 0) ? 16'h0100 : 16'h1234;
        yi_m[k][a] = (a == 0) ? 16'h0000 : 16'h0055;
        zr_e[k][a] = 16'h0000;
        zi_e[k][a] = (a == 0) ? 16'hFF00 : 16'h0000;
      end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 0; bus.h_valid = 0; bus.y_valid = 0; bus.z_ready = 1;
    bus.h_r = 0; bus.h_i = 0; bus.y_r = 0; bus.y_i = 0;
    @(negedge clk);
    chk("rst_h_ready", 32'(bus.h_ready), 0);
    chk("rst_y_ready", 32'(bus.y_ready), 0);
    chk("rst_z_valid", 32'(bus.z_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sat", 32'(bus.sat_flag), 0);
    chk("rst_z_r", 32'(bus.z_r), 0);
    chk("rst_z_i", 32'(bus.z_i), 0);
    chk("rst_z_tx", 32'(bus.z_tx), 0);
    chk("rst_z_sym", 32'(bus.z_sym), 0);
    @(posedge clk);
    #1 rst_n = 1;
    set_identity();
    start_pulse();
    load_h();
    send_y(0, 4, 1);
    send_y(1, 4, 1);
    wait_done("ident");
    set_conj();
    start_pulse();
    load_h();
    send_y(0, 4, 1);
    send_y(1, 4, 1);
    wait_done("conj");
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        hr_m[a][b] = 16'h7FFF;
        hi_m[a][b] = 16'h0000;
      end
      for (int k = 0; k < 2; k++) begin
        yr_m[k][a] = 16'h7FFF;
        yi_m[k][a] = 16'h0000;
        zr_e[k][a] = 16'h7FFF;
        zi_e[k][a] = 16'h0000;
      end
    end
    start_pulse();
    load_h();
    send_y(0, 4, 1);
    send_y(1, 4, 1);
    wait_done("sat");
    chk("sat_sticky", 32'(bus.sat_flag), 1);
    set_identity();
    start_pulse();
    @(negedge clk);
    chk("bp_sat_cleared", 32'(bus.sat_flag), 0);
    chk("bp_load_h_ready", 32'(bus.h_ready), 1);
    @(posedge clk);
    #1 bus.z_ready = 0;
    load_h();
    send_y(0, 4, 1);
    wait_zvalid("bp_zvalid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(bus.z_valid), 1);
      chk("bp_hold_z_r", 32'(bus.z_r), 32'h0100);
      chk("bp_hold_z_i", 32'(bus.z_i), 0);
      chk("bp_hold_tx", 32'(bus.z_tx), 0);
      chk("bp_hold_y_ready", 32'(bus.y_ready), 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 bus.z_ready = 1;
    begin
      int cnt = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus.z_valid && bus.z_ready) cnt++;
      end
      chk("bp_burst_beats", cnt, 4);
    end
    @(negedge clk);
    chk("bp_y_ready_after", 32'(bus.y_ready), 1);
    @(posedge clk);
    #1;
    send_y(1, 4, 1);
    wait_done("bp");
    set_identity();
    start_pulse();
    load_h();
    send_y(0, 2, 0);
    start_pulse();
    @(negedge clk);
    chk("restart_h_ready", 32'(bus.h_ready), 1);
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_y_ready", 32'(bus.y_ready), 0);
    chk("restart_z_valid", 32'(bus.z_valid), 0);
    @(posedge clk);
    #1;
    set_conj();
    load_h();
    send_y(0, 4, 1);
    send_y(1, 4, 1);
    wait_done("restart");
    set_identity();
    bus.z_ready = 0;
    start_pulse();
    load_h();
    send_y(0, 4, 0);
    wait_zvalid("rst_mid_zvalid");
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_z_valid", 32'(bus.z_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_z_r", 32'(bus.z_r), 0);
    chk("arst_z_i", 32'(bus.z_i), 0);
    chk("arst_z_tx", 32'(bus.z_tx), 0);
    chk("arst_z_sym", 32'(bus.z_sym), 0);
    chk("arst_h_ready", 32'(bus.h_ready), 0);
    chk("arst_y_ready", 32'(bus.y_ready), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(posedge clk);
    #1 rst_n = 1;
    bus.z_ready = 1;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_z_valid", 32'(bus.z_valid), 0);
    @(posedge clk);
    #1;
    start_pulse();
    load_h();
    send_y(0, 4, 1);
    send_y(1, 4, 1);
    wait_done("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
